risc_spm: RTL and testbench
===========================

RISC_SPM -- requirements
Module: risc_spm

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have port load_en  input  1  memory load strobe; writes load_data to mem[load_addr] on clk rise.
REQ-005 SHALL have port load_addr  input  8  load address.
REQ-006 SHALL have port load_data  input  8  load data.
REQ-007 SHALL have ports pc, ir  output  8 each  program counter and instruction register.
REQ-008 SHALL have ports r0, r1, r2, r3  output  8 each  general registers.
REQ-009 SHALL have port zero_flag  output  1  Z flag.
REQ-010 SHALL have port halted  output  1  high while in HALT state.

Function
REQ-011 SHALL contain a 256x8 memory with combinational read and clocked write; load_en write has priority over CPU WR in the same cycle.
REQ-012 SHALL use instruction byte format opcode[7:4], src[3:2], dest[1:0]; RD, WR, BR and BRZ take a second byte holding an 8-bit address.
REQ-013 SHALL decode opcodes as: 0 NOP, 1 ADD (dest=dest+src), 2 SUB (dest=dest-src), 3 AND (dest=dest&src), 4 NOT (dest=~src), 5 RD (dest=mem[addr]), 6 WR (mem[addr]=src), 7 BR (pc=addr), 8 BRZ (pc=addr if Z), F HALT; 9-E are illegal.
REQ-014 SHALL perform modulo-256 arithmetic, dropping carry and borrow; Z updates only on ADD, SUB, AND, NOT and equals (result==0).
REQ-015 SHALL use FSM states IDLE, FET1, FET2, DEC, EX1, RD1, RD2, RD3, WR1, WR2, WR3, BR1, BR2, HALT.
REQ-016 Fetch and decode SHALL be: IDLE->FET1; FET1: mar<=pc; FET2: ir<=mem[mar], pc<=pc+1; then DEC.
REQ-017 DEC SHALL branch as: NOP->FET1; ALU ops->EX1, where the result is written to dest and Z is updated, then FET1.
REQ-018 RD SHALL run RD1 (mar<=pc), RD2 (mar<=mem[mar], pc<=pc+1), RD3 (dest<=mem[mar]), then FET1.
REQ-019 WR SHALL run WR1, WR2 as RD1, RD2, then WR3 (mem[mar]<=src), then FET1.
REQ-020 BR, and BRZ with Z=1, SHALL run BR1 (mar<=pc), BR2 (pc<=mem[mar]), then FET1; BRZ with Z=0 SHALL do pc<=pc+1 in DEC, then FET1.
REQ-021 HALT SHALL hold all state and keep halted=1 until rst.
REQ-022 pc SHALL wrap from 0xFF to 0x00.
REQ-023 When src==dest, the ALU SHALL use the pre-update register value.

Reset
REQ-024 rst SHALL immediately force: FSM=IDLE; pc, ir, mar, r0-r3 = 0x00; zero_flag=0; halted=0.
REQ-025 Memory SHALL NOT be cleared by rst; load_en SHALL remain functional while rst is high.
REQ-026 rst asserted mid-instruction SHALL abort it, with no memory or register write afterwards.

Configuration
REQ-027 With macro RISC_SPM_ILLEGAL_HALT_EN defined, opcodes 9-E SHALL go from DEC to HALT (halted=1).
REQ-028 Without RISC_SPM_ILLEGAL_HALT_EN, opcodes 9-E SHALL execute as NOP.

Verification
REQ-029 Reset: with rst=1, load mem[0]=0xF0; release rst -> pc=0x01 and halted=1 within 4 clocks, r0-r3=0.
REQ-030 RD/ALU: program 51 80 52 81 16 F0 with mem[80]=05, mem[81]=FB -> r1=05, r2=00, zero_flag=1, halted.
REQ-031 WR: program 51 80 64 90 F0 with mem[80]=3C -> mem[90]=3C, zero_flag unchanged at 0.
REQ-032 BRZ: with Z=0, 80 10 passes through; after SUB r0-r0 (0x20), 80 10 -> pc=0x10 on the next fetch.
REQ-033 Illegal: opcode 0xA0 -> halted=1 if RISC_SPM_ILLEGAL_HALT_EN is defined, else pc advances by 1.
REQ-034 Async reset: assert rst during WR2 -> mem[addr] unchanged, all registers 0 without waiting for a clock edge.

Source files
------------

// File: rtl/risc_spm.sv
// RISC_SPM: small stored-program CPU with a 256x8 unified memory and four general registers.
// Define RISC_SPM_ILLEGAL_HALT_EN to send opcodes 9-E to HALT; otherwise they execute as NOP.
module risc_spm (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_en,
    input  logic [7:0] load_addr,
    input  logic [7:0] load_data,
    output logic [7:0] pc,
    output logic [7:0] ir,
    output logic [7:0] r0,
    output logic [7:0] r1,
    output logic [7:0] r2,
    output logic [7:0] r3,
    output logic       zero_flag,
    output logic       halted
);

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned NREG  = 4;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_NOT  = 4'h4;
    localparam logic [3:0] OP_RD   = 4'h5;
    localparam logic [3:0] OP_WR   = 4'h6;
    localparam logic [3:0] OP_BR   = 4'h7;
    localparam logic [3:0] OP_BRZ  = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [3:0] {
        S_IDLE, S_FET1, S_FET2, S_DEC, S_EX1,
        S_RD1, S_RD2, S_RD3, S_WR1, S_WR2, S_WR3,
        S_BR1, S_BR2, S_HALT
    } state_t;

    state_t                  state, state_n;
    logic [DW-1:0]           mem [DEPTH];
    logic [DW-1:0]           mar, mar_n, pc_n, ir_n;
    logic [NREG-1:0][DW-1:0] regs, regs_n;
    logic                    zf_n, halted_n, mem_we;
    logic [3:0]              op;
    logic [1:0]              src, dst;
    logic [DW-1:0]           mem_rd, a_val, b_val, alu_res;

    assign op     = ir[7:4];
    assign src    = ir[3:2];
    assign dst    = ir[1:0];
    assign mem_rd = mem[mar];
    // Operands come from the current register file, so src==dest sees the old value.
    assign a_val  = regs[dst];
    assign b_val  = regs[src];

    assign r0 = regs[0];
    assign r1 = regs[1];
    assign r2 = regs[2];
    assign r3 = regs[3];

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = a_val + b_val;
            OP_SUB:  alu_res = a_val - b_val;
            OP_AND:  alu_res = a_val & b_val;
            OP_NOT:  alu_res = ~b_val;
            default: alu_res = '0;
        endcase
    end

    // Next-state and datapath control.
    always_comb begin
        state_n = state;
        mar_n   = mar;
        pc_n    = pc;
        ir_n    = ir;
        regs_n  = regs;
        zf_n    = zero_flag;
        mem_we  = 1'b0;
        case (state)
            S_IDLE: state_n = S_FET1;
            S_FET1: begin
                mar_n   = pc;
                state_n = S_FET2;
            end
            S_FET2: begin
                ir_n    = mem_rd;
                pc_n    = pc + 8'd1;
                state_n = S_DEC;
            end
            S_DEC: begin
                case (op)
                    OP_NOP:                         state_n = S_FET1;
                    OP_ADD, OP_SUB, OP_AND, OP_NOT: state_n = S_EX1;
                    OP_RD:                          state_n = S_RD1;
                    OP_WR:                          state_n = S_WR1;
                    OP_BR:                          state_n = S_BR1;
                    OP_BRZ: begin
                        if (zero_flag) begin
                            state_n = S_BR1;
                        end else begin
                            pc_n    = pc + 8'd1;
                            state_n = S_FET1;
                        end
                    end
                    OP_HALT:                        state_n = S_HALT;
                    default: begin
`ifdef RISC_SPM_ILLEGAL_HALT_EN
                        state_n = S_HALT;
`else
                        state_n = S_FET1;
`endif
                    end
                endcase
            end
            S_EX1: begin
                regs_n[dst] = alu_res;
                zf_n        = (alu_res == '0);
                state_n     = S_FET1;
            end
            S_RD1, S_WR1, S_BR1: begin
                mar_n = pc;
                if (state == S_RD1)      state_n = S_RD2;
                else if (state == S_WR1) state_n = S_WR2;
                else                     state_n = S_BR2;
            end
            S_RD2, S_WR2: begin
                mar_n   = mem_rd;
                pc_n    = pc + 8'd1;
                state_n = (state == S_RD2) ? S_RD3 : S_WR3;
            end
            S_RD3: begin
                regs_n[dst] = mem_rd;
                state_n     = S_FET1;
            end
            S_WR3: begin
                mem_we  = 1'b1;
                state_n = S_FET1;
            end
            S_BR2: begin
                pc_n    = mem_rd;
                state_n = S_FET1;
            end
            S_HALT:  state_n = S_HALT;
            default: state_n = S_IDLE;
        endcase
        halted_n = (state_n == S_HALT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= '0;
            ir        <= '0;
            mar       <= '0;
            regs      <= '0;
            zero_flag <= 1'b0;
            halted    <= 1'b0;
        end else begin
            pc        <= pc_n;
            ir        <= ir_n;
            mar       <= mar_n;
            regs      <= regs_n;
            zero_flag <= zf_n;
            halted    <= halted_n;
        end
    end

    // Memory is never reset; the external load port wins over a CPU store.
    always_ff @(posedge clk) begin
        if (load_en)     mem[load_addr] <= load_data;
        else if (mem_we) mem[mar]       <= b_val;
    end

endmodule

// File: tb/tb_risc_spm.sv
// Randomized + directed bench for risc_spm: an instruction-level interpreter predicts the
// architectural state at HALT; a monitor compares it whenever halted rises.
module tb_risc_spm;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_en;
    logic [7:0] load_addr, load_data;
    logic [7:0] pc, ir, r0, r1, r2, r3;
    logic       zero_flag, halted;

    risc_spm dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .pc(pc), .ir(ir), .r0(r0), .r1(r1), .r2(r2), .r3(r3),
        .zero_flag(zero_flag), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]      pc;
        logic [7:0]      ir;
        logic [3:0][7:0] r;
        logic            z;
        int              id;
    } exp_t;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] shadow [256];
    exp_t       exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Architectural interpreter: fetch, advance pc, execute, until HALT.
    task automatic model_run(output exp_t e);
        logic [7:0] p, i, a, res;
        logic [7:0] r [4];
        logic       z;
        bit         done;
        p = 8'h00; i = 8'h00; z = 1'b0; done = 0;
        for (int k = 0; k < 4; k++) r[k] = 8'h00;
        for (int step = 0; step < 2000 && !done; step++) begin
            i = shadow[p];
            p = p + 8'd1;
            case (i[7:4])
                4'h0: ;
                4'h1, 4'h2, 4'h3, 4'h4: begin
                    case (i[7:4])
                        4'h1:    res = r[i[1:0]] + r[i[3:2]];
                        4'h2:    res = r[i[1:0]] - r[i[3:2]];
                        4'h3:    res = r[i[1:0]] & r[i[3:2]];
                        default: res = ~r[i[3:2]];
                    endcase
                    r[i[1:0]] = res;
                    z = (res == 8'h00);
                end
                4'h5: begin a = shadow[p]; p = p + 8'd1; r[i[1:0]] = shadow[a]; end
                4'h6: begin a = shadow[p]; p = p + 8'd1; shadow[a] = r[i[3:2]]; end
                4'h7: p = shadow[p];
                4'h8: if (z) p = shadow[p]; else p = p + 8'd1;
                4'hF: done = 1;
                default: begin
`ifdef RISC_SPM_ILLEGAL_HALT_EN
                    done = 1;
`endif
                end
            endcase
        end
        e.pc = p;
        e.ir = i;
        for (int k = 0; k < 4; k++) e.r[k] = r[k];
        e.z  = z;
        e.id = 0;
    endtask

    task automatic load_byte(input logic [7:0] a, input logic [7:0] d);
        load_addr = a;
        load_data = d;
        load_en   = 1'b1;
        shadow[a] = d;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    // Predict, release reset, wait for the monitor to consume the expectation, check HALT holds.
    task automatic run_check(input int id);
        exp_t e;
        model_run(e);
        e.id = id;
        exp_q.push_back(e);
        rst = 1'b0;
        for (int c = 0; c < 3000 && exp_q.size() != 0; c++) @(negedge clk);
        check($sformatf("timeout#%0d", id), 32'(exp_q.size()), 32'd0);
        if (exp_q.size() != 0) begin
            exp_q.delete();
        end else begin
            repeat (3) @(negedge clk);
            check($sformatf("hold_halted#%0d", id), 32'(halted), 32'd1);
            check($sformatf("hold_pc#%0d", id), 32'(pc), 32'(e.pc));
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic rand_test(input int id);
        int          n, pos, op, tgt;
        int          start [14];
        logic [3:0]  ops [13];
        logic [7:0]  img [256];
        for (int a = 0; a < 256; a++) img[a] = 8'($urandom);
        n = $urandom_range(3, 12);
        pos = 0;
        for (int i = 0; i < n; i++) begin
            ops[i]   = 4'($urandom_range(0, 14));
            start[i] = pos;
            pos += (ops[i] >= 4'h5 && ops[i] <= 4'h8) ? 2 : 1;
        end
        start[n] = pos;
        for (int i = 0; i < n; i++) begin
            op = int'(ops[i]);
            img[start[i]] = {ops[i], 4'($urandom)};
            if (op == 5 || op == 6) img[start[i] + 1] = 8'h80 + 8'($urandom_range(0, 7));
            if (op == 7 || op == 8) begin
                tgt = $urandom_range(i + 1, n);
                img[start[i] + 1] = 8'(start[tgt]);
            end
        end
        img[start[n]] = {4'hF, 4'($urandom)};
        for (int a = 0; a < 256; a++) load_byte(8'(a), img[a]);
        run_check(id);
    endtask

    // Monitor: each rising edge of halted consumes one expectation.
    initial begin
        logic hq;
        exp_t e;
        hq = 1'b0;
        forever begin
            @(negedge clk);
            if (halted === 1'b1 && hq !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_halt", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("pc#%0d", e.id), 32'(pc), 32'(e.pc));
                    check($sformatf("ir#%0d", e.id), 32'(ir), 32'(e.ir));
                    check($sformatf("r0#%0d", e.id), 32'(r0), 32'(e.r[0]));
                    check($sformatf("r1#%0d", e.id), 32'(r1), 32'(e.r[1]));
                    check($sformatf("r2#%0d", e.id), 32'(r2), 32'(e.r[2]));
                    check($sformatf("r3#%0d", e.id), 32'(r3), 32'(e.r[3]));
                    check($sformatf("z#%0d", e.id), 32'(zero_flag), 32'(e.z));
                end
            end
            hq = halted;
        end
    end

    initial begin
        bit found;
        rst = 1'b1; load_en = 1'b0; load_addr = 8'h00; load_data = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_ir", 32'(ir), 32'd0);
        check("rst_r0", 32'(r0), 32'd0);
        check("rst_r3", 32'(r3), 32'd0);
        check("rst_z", 32'(zero_flag), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);

        for (int a = 0; a < 256; a++) load_byte(8'(a), 8'h00);

        // Immediate HALT out of reset
        load_byte(8'h00, 8'hF0);
        run_check(1);

        // RD / ADD to zero
        load_byte(8'h00, 8'h51); load_byte(8'h01, 8'h80); load_byte(8'h02, 8'h52);
        load_byte(8'h03, 8'h81); load_byte(8'h04, 8'h16); load_byte(8'h05, 8'hF0);
        load_byte(8'h80, 8'h05); load_byte(8'h81, 8'hFB);
        run_check(2);

        // WR then read the stored byte back in a second program
        load_byte(8'h00, 8'h51); load_byte(8'h01, 8'h80); load_byte(8'h02, 8'h64);
        load_byte(8'h03, 8'h90); load_byte(8'h04, 8'hF0); load_byte(8'h80, 8'h3C);
        run_check(3);
        load_byte(8'h00, 8'h51); load_byte(8'h01, 8'h90); load_byte(8'h02, 8'hF0);
        run_check(4);

        // BRZ not taken, then taken after SUB r0-r0
        load_byte(8'h00, 8'h80); load_byte(8'h01, 8'h10); load_byte(8'h02, 8'h20);
        load_byte(8'h03, 8'h80); load_byte(8'h04, 8'h10); load_byte(8'h05, 8'hF0);
        load_byte(8'h10, 8'hF0);
        run_check(5);

        // pc wrap from FF to 00
        load_byte(8'h00, 8'h80); load_byte(8'h01, 8'h05); load_byte(8'h02, 8'h20);
        load_byte(8'h03, 8'h70); load_byte(8'h04, 8'hFF); load_byte(8'h05, 8'hF0);
        load_byte(8'hFF, 8'h00);
        run_check(6);

        // Illegal opcode
        load_byte(8'h00, 8'hA0); load_byte(8'h01, 8'hF0);
        run_check(7);

        // Async reset during WR2 must abort the store and clear registers at once
        load_byte(8'h00, 8'h51); load_byte(8'h01, 8'h80); load_byte(8'h02, 8'h64);
        load_byte(8'h03, 8'h90); load_byte(8'h04, 8'hF0);
        load_byte(8'h80, 8'hAB); load_byte(8'h90, 8'h77);
        rst = 1'b0;
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (ir === 8'h64) found = 1;
        end
        check("abort_reach_wr", 32'(ir), 32'h64);
        if (found) begin
            @(posedge clk);
            @(posedge clk);
            #2 rst = 1'b1;
            #1;
            check("abort_pc", 32'(pc), 32'd0);
            check("abort_ir", 32'(ir), 32'd0);
            check("abort_r0", 32'(r0), 32'd0);
            check("abort_r1", 32'(r1), 32'd0);
            check("abort_r2", 32'(r2), 32'd0);
            check("abort_r3", 32'(r3), 32'd0);
            check("abort_z", 32'(zero_flag), 32'd0);
            check("abort_halted", 32'(halted), 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        load_byte(8'h00, 8'h51); load_byte(8'h01, 8'h90); load_byte(8'h02, 8'hF0);
        run_check(8);

        for (int t = 0; t < 25; t++) rand_test(100 + t);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
